// File: rtl/jtframe_dwnld_pack.sv
// Download packer: splits the ioctl byte stream into regions, packs byte
// pairs into 16-bit words and queues them in a 2-entry buffer for the SDRAM.
module jtframe_dwnld_pack #(
  parameter int unsigned              AW        = 22,
  parameter int unsigned              REGIONS   = 4,
  parameter int unsigned              RW        = 2,
  parameter logic [REGIONS*AW-1:0]    REG_START = {22'h30000, 22'h20000, 22'h10000, 22'h0},
  parameter bit                       SWAB      = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-2:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic [RW-1:0] prog_region,
  output logic          prog_we,
  input  logic          prog_ack,
  output logic          dwnld_busy,
  output logic          overflow
);

  localparam int unsigned EW = (AW - 1) + 16 + 2 + RW;

  logic [RW-1:0] sel_region;
  logic [AW-1:0] sel_start;
  logic [AW-1:0] rel;
  logic          accept;
  logic          same_word;
  logic          complete;
  logic          flush_half;
  logic          push;
  logic          pop;
  logic          dl_q;

  logic          half_valid;
  logic          half_lane;
  logic [AW-2:0] half_addr;
  logic [RW-1:0] half_region;
  logic [7:0]    half_data;

  logic [7:0]    lane0_byte;
  logic [7:0]    lane1_byte;
  logic [1:0]    lane_mask;
  logic [EW-1:0] new_entry;
  logic [EW-1:0] tail_entry;
  logic          tail_valid;

  // Region decode: highest region whose start is not above the byte address
  always_comb begin
    sel_region = '0;
    sel_start  = '0;
    for (int unsigned k = 0; k < REGIONS; k++) begin
      if (ioctl_addr >= REG_START[k*AW +: AW]) begin
        sel_region = RW'(k);
        sel_start  = REG_START[k*AW +: AW];
      end
    end
  end

  assign rel        = ioctl_addr - sel_start;
  assign accept     = ioctl_wr & downloading;
  assign same_word  = half_valid && (half_addr == rel[AW-1:1]) && (half_region == sel_region);
  assign complete   = accept && same_word && (rel[0] != half_lane);
  assign flush_half = (accept && half_valid && !same_word) || (!downloading && dl_q && half_valid);
  assign push       = complete | flush_half;
  assign pop        = prog_ack & prog_we;
  assign dwnld_busy = downloading | half_valid | prog_we;

  // Build the word to push: a completed pair or the pending half with its empty lane masked
  always_comb begin
    lane0_byte = '0;
    lane1_byte = '0;
    lane_mask  = 2'b11;
    new_entry  = '0;
    if (complete) begin
      lane0_byte = half_lane ? ioctl_data : half_data;
      lane1_byte = half_lane ? half_data : ioctl_data;
      lane_mask  = 2'b00;
    end else if (half_lane) begin
      lane1_byte = half_data;
      lane_mask  = 2'b01;
    end else begin
      lane0_byte = half_data;
      lane_mask  = 2'b10;
    end
    if (SWAB) new_entry = {half_addr, lane0_byte, lane1_byte, lane_mask[0], lane_mask[1], half_region};
    else      new_entry = {half_addr, lane1_byte, lane0_byte, lane_mask, half_region};
  end

  // Half-word latch and download-window edge tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      half_valid  <= 1'b0;
      half_lane   <= 1'b0;
      half_addr   <= '0;
      half_region <= '0;
      half_data   <= '0;
      dl_q        <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (accept) begin
        if (complete) begin
          half_valid <= 1'b0;
        end else begin
          half_valid  <= 1'b1;
          half_lane   <= rel[0];
          half_addr   <= rel[AW-1:1];
          half_region <= sel_region;
          half_data   <= ioctl_data;
        end
      end else if (flush_half) begin
        half_valid <= 1'b0;
      end
    end
  end

  // Two-entry word buffer; the head register drives the prog_* outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_addr   <= '0;
      prog_data   <= '0;
      prog_mask   <= 2'b11;
      prog_region <= '0;
      prog_we     <= 1'b0;
      tail_entry  <= '0;
      tail_valid  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case ({prog_we, tail_valid})
        2'b00: begin
          if (push) begin
            {prog_addr, prog_data, prog_mask, prog_region} <= new_entry;
            prog_we <= 1'b1;
          end
        end
        2'b10: begin
          if (pop && push) begin
            {prog_addr, prog_data, prog_mask, prog_region} <= new_entry;
          end else if (pop) begin
            prog_we <= 1'b0;
          end else if (push) begin
            tail_entry <= new_entry;
            tail_valid <= 1'b1;
          end
        end
        2'b11: begin
          if (pop) begin
            {prog_addr, prog_data, prog_mask, prog_region} <= tail_entry;
            if (push) tail_entry <= new_entry;
            else      tail_valid <= 1'b0;
          end else if (push) begin
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Bench for jtframe_dwnld_pack: directed steps plus random traffic, both lane
// mappings, checked every cycle against a queue-based reference model.
module tb_jtframe_dwnld_pack;

  localparam int unsigned AW = 22;

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [1:0]    lm;
    logic [1:0]    region;
  } word_t;

  logic          clk;
  logic          rst;
  logic          downloading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          prog_ack;

  logic [AW-2:0] prog_addr0, prog_addr1;
  logic [15:0]   prog_data0, prog_data1;
  logic [1:0]    prog_mask0, prog_mask1;
  logic [1:0]    prog_region0, prog_region1;
  logic          prog_we0, prog_we1;
  logic          dwnld_busy0, dwnld_busy1;
  logic          overflow0, overflow1;

  int checks   = 0;
  int failures = 0;

  word_t         exp_q[$];
  logic          pend_valid;
  logic [1:0]    pend_region;
  logic [AW-1:0] pend_rel;
  logic [7:0]    pend_byte;
  logic          exp_ovf;
  logic          dl_prev;

  jtframe_dwnld_pack #(.SWAB(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr0), .prog_data(prog_data0), .prog_mask(prog_mask0),
    .prog_region(prog_region0), .prog_we(prog_we0), .prog_ack(prog_ack),
    .dwnld_busy(dwnld_busy0), .overflow(overflow0)
  );

  jtframe_dwnld_pack #(.SWAB(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr1), .prog_data(prog_data1), .prog_mask(prog_mask1),
    .prog_region(prog_region1), .prog_we(prog_we1), .prog_ack(prog_ack),
    .dwnld_busy(dwnld_busy1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Regions are 64 KiB apart, the last one is open-ended
  function automatic logic [1:0] region_of(input logic [AW-1:0] a);
    return (a[AW-1:16] > 6'd3) ? 2'd3 : a[17:16];
  endfunction

  function automatic logic [AW-1:0] start_of(input logic [1:0] r);
    return AW'(r) << 16;
  endfunction

  function automatic word_t partial_word();
    word_t w;
    w.addr   = pend_rel[AW-1:1];
    w.region = pend_region;
    w.b0     = pend_rel[0] ? 8'h00 : pend_byte;
    w.b1     = pend_rel[0] ? pend_byte : 8'h00;
    w.lm     = pend_rel[0] ? 2'b01 : 2'b10;
    return w;
  endfunction

  // Reference model: advance one clock edge using the inputs currently applied
  task automatic model_edge();
    word_t         w;
    logic          have;
    logic [1:0]    r;
    logic [AW-1:0] rel;
    have = 1'b0;
    w    = '0;
    if (rst) begin
      exp_q.delete();
      pend_valid = 1'b0;
      exp_ovf    = 1'b0;
      dl_prev    = 1'b0;
      return;
    end
    if (ioctl_wr && downloading) begin
      r   = region_of(ioctl_addr);
      rel = ioctl_addr - start_of(r);
      if (pend_valid && pend_region == r && pend_rel[AW-1:1] == rel[AW-1:1]) begin
        if (pend_rel[0] != rel[0]) begin
          w.addr     = rel[AW-1:1];
          w.region   = r;
          w.lm       = 2'b00;
          w.b0       = rel[0] ? pend_byte : ioctl_data;
          w.b1       = rel[0] ? ioctl_data : pend_byte;
          have       = 1'b1;
          pend_valid = 1'b0;
        end else begin
          pend_byte = ioctl_data;
        end
      end else begin
        if (pend_valid) begin
          w    = partial_word();
          have = 1'b1;
        end
        pend_valid  = 1'b1;
        pend_region = r;
        pend_rel    = rel;
        pend_byte   = ioctl_data;
      end
    end else if (!downloading && dl_prev && pend_valid) begin
      w          = partial_word();
      have       = 1'b1;
      pend_valid = 1'b0;
    end
    dl_prev = downloading;
    if (prog_ack && exp_q.size() != 0) void'(exp_q.pop_front());
    if (have) begin
      if (exp_q.size() >= 2) exp_ovf = 1'b1;
      else                   exp_q.push_back(w);
    end
  endtask

  task automatic check_all();
    word_t h;
    logic  busy;
    busy = downloading | pend_valid | (exp_q.size() != 0);
    chk("we0",   32'(prog_we0),    32'(exp_q.size() != 0));
    chk("we1",   32'(prog_we1),    32'(exp_q.size() != 0));
    chk("ovf0",  32'(overflow0),   32'(exp_ovf));
    chk("ovf1",  32'(overflow1),   32'(exp_ovf));
    chk("busy0", 32'(dwnld_busy0), 32'(busy));
    chk("busy1", 32'(dwnld_busy1), 32'(busy));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("addr0",   32'(prog_addr0),   32'(h.addr));
      chk("addr1",   32'(prog_addr1),   32'(h.addr));
      chk("region0", 32'(prog_region0), 32'(h.region));
      chk("region1", 32'(prog_region1), 32'(h.region));
      chk("data0",   32'(prog_data0),   32'({h.b1, h.b0}));
      chk("data1",   32'(prog_data1),   32'({h.b0, h.b1}));
      chk("mask0",   32'(prog_mask0),   32'(h.lm));
      chk("mask1",   32'(prog_mask1),   32'({h.lm[0], h.lm[1]}));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  logic [AW-1:0] bases [7];
  logic [AW-1:0] last;

  initial begin
    bases = '{22'h0, 22'hFFF8, 22'h10000, 22'h1FFFC, 22'h20000, 22'h30000, 22'h3FFFF8};
    pend_valid  = 1'b0;
    pend_region = '0;
    pend_rel    = '0;
    pend_byte   = '0;
    exp_ovf     = 1'b0;
    dl_prev     = 1'b0;
    rst         = 1'b1;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_data  = '0;
    ioctl_wr    = 1'b0;
    prog_ack    = 1'b1;

    // Reset defaults
    step();
    step();
    rst = 1'b0;
    chk("rst_mask",   32'(prog_mask0),   32'h3);
    chk("rst_data",   32'(prog_data0),   32'h0);
    chk("rst_addr",   32'(prog_addr0),   32'h0);
    chk("rst_region", 32'(prog_region0), 32'h0);
    chk("rst_busy",   32'(dwnld_busy0),  32'h0);

    // Basic pair, one-cycle latency, single-cycle prog_we with ack held high
    downloading = 1'b1;
    step();
    wr_byte(22'h0, 8'h12);
    chk("t1_we_early", 32'(prog_we0), 32'h0);
    wr_byte(22'h1, 8'h34);
    chk("t1_data", 32'(prog_data0), 32'h3412);
    chk("t1_mask", 32'(prog_mask0), 32'h0);
    step();
    chk("t1_we_drop", 32'(prog_we0), 32'h0);

    // Region decode, both lane mappings
    wr_byte(22'h10004, 8'hAB);
    wr_byte(22'h10005, 8'hCD);
    chk("t2_region", 32'(prog_region0), 32'h1);
    chk("t2_addr",   32'(prog_addr0),   32'h2);
    chk("t2_data0",  32'(prog_data0),   32'hCDAB);
    chk("t2_data1",  32'(prog_data1),   32'hABCD);
    step();

    // Odd tail flushed on the falling edge of downloading
    wr_byte(22'h7, 8'h5A);
    downloading = 1'b0;
    step();
    chk("t3_addr", 32'(prog_addr0),  32'h3);
    chk("t3_mask", 32'(prog_mask0),  32'h1);
    chk("t3_data", 32'(prog_data0),  32'h5A00);
    chk("t3_busy", 32'(dwnld_busy0), 32'h1);
    step();
    chk("t3_busy_low", 32'(dwnld_busy0), 32'h0);

    // Backpressure: third word dropped, overflow sticky until reset
    downloading = 1'b1;
    prog_ack    = 1'b0;
    for (int i = 0; i < 6; i++) wr_byte(AW'(32'h20 + i), 8'(8'h40 + i));
    chk("t4_ovf", 32'(overflow0), 32'h1);
    prog_ack = 1'b1;
    idle(3);
    chk("t4_ovf_sticky", 32'(overflow0), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_ovf_clear", 32'(overflow0), 32'h0);

    // Non-sequential writes: partial flush then a full word
    wr_byte(22'h0, 8'h11);
    wr_byte(22'h4, 8'h22);
    chk("t5_pmask", 32'(prog_mask0), 32'h2);
    chk("t5_paddr", 32'(prog_addr0), 32'h0);
    wr_byte(22'h5, 8'h33);
    chk("t5_faddr", 32'(prog_addr0), 32'h2);
    chk("t5_fmask", 32'(prog_mask0), 32'h0);
    chk("t5_fdata", 32'(prog_data0), 32'h3322);

    // Reset mid-burst discards everything, no flush afterwards
    prog_ack = 1'b0;
    wr_byte(22'h8, 8'h01);
    wr_byte(22'h9, 8'h02);
    wr_byte(22'hA, 8'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_we_rst", 32'(prog_we0), 32'h0);
    downloading = 1'b0;
    idle(3);
    chk("t6_we_none", 32'(prog_we0), 32'h0);
    prog_ack = 1'b1;

    // Random traffic around region boundaries
    last = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) downloading = ~downloading;
      rst      = ($urandom_range(0, 199) == 0);
      prog_ack = ($urandom_range(0, 99) < 70);
      ioctl_wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) last = last + 1'b1;
      else last = bases[$urandom_range(0, 6)] + AW'($urandom_range(0, 7));
      ioctl_addr = last;
      ioctl_data = 8'($urandom);
      step();
    end
    ioctl_wr    = 1'b0;
    rst         = 1'b0;
    downloading = 1'b0;
    prog_ack    = 1'b1;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_dwnld_pack.md
# jtframe_dwnld_pack

Download packer and router between the HPS ioctl byte stream and the SDRAM programming port of a jtframe core. It splits the flat ROM file into up to `REGIONS` address regions and packs byte pairs into 16-bit words. A 2-entry word buffer rides out SDRAM acknowledge latency. Partial words are flushed with a byte mask. It replaces the fixed `prog_*` tie-offs in game top levels and feeds `jtframe_mister` directly.

## Interface
Parameters:
- `AW`, 22: ioctl byte-address width.
- `REGIONS`, 4: number of regions, 1..8.
- `RW`, 2: region index width, with `2**RW >= REGIONS`.
- `REG_START`, `{22'h30000,22'h20000,22'h10000,22'h0}`: packed `REGIONS*AW` start byte addresses. Entry k sits at bits `[k*AW +: AW]`. Entries are ascending, and entry 0 must be 0.
- `SWAB`, 0: when 1, the even byte goes to `[15:8]` instead of `[7:0]`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `downloading` in 1: HPS download window.
- `ioctl_addr` in AW: byte address.
- `ioctl_data` in 8: byte.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `prog_addr` out AW-1: word address relative to the start of the region.
- `prog_data` out 16: packed word.
- `prog_mask` out 2: per-byte write mask; a 1 means that byte is not written. Bit 0 covers `[7:0]`.
- `prog_region` out RW: region index of the presented word.
- `prog_we` out 1: word valid; held high until acknowledged.
- `prog_ack` in 1: SDRAM accepted the presented word this cycle.
- `dwnld_busy` out 1: this block or the SDRAM is still busy with the download.
- `overflow` out 1: sticky flag; a word was dropped because the buffer was full.

## Operation
- **Byte acceptance:** a byte is taken only on a cycle with `ioctl_wr & downloading`.
- **Region decode:** k is the highest index with `REG_START[k] <= ioctl_addr`. The relative address is `rel = ioctl_addr - REG_START[k]`, and the word address is `rel[AW-1:1]`.
- **Half-word latch:** one pending byte with its word address, region and lane (`rel[0]`).
  - A new byte with the same word address and region, in the opposite lane, completes the word and pushes it with `prog_mask=00`. The half latch then clears.
  - Any other new byte first pushes the pending half as a partial word, masked on the empty lane (`10` if only the low lane is valid, `01` if only the high lane). The new byte then becomes pending.
  - When the new byte completes a word and the same-lane/odd case does not apply, only one push happens per cycle. The partial flush plus new-pending case is also a single push.
  - A byte that arrives for the same lane and address as the pending byte replaces it without pushing.
- **Flush at end of download:** on the falling edge of `downloading`, a pending half is pushed as a partial word.
- **Lane mapping:** with `SWAB=0`, lane 0 maps to `[7:0]`. With `SWAB=1`, lane 0 maps to `[15:8]` and the mask bits swap to match. Unused data bits read 0.
- **Buffer:** 2-entry FIFO holding `{addr, data, mask, region}`. Its head drives the `prog_*` outputs, and `prog_we = !empty`.
  - A pop happens on a cycle with `prog_ack & prog_we`.
  - Push and pop in the same cycle are legal at any fill level, including full.
  - A push while the FIFO is full with no pop drops the word and sets `overflow`. Only `rst` clears `overflow`.
- **Busy:** `dwnld_busy = downloading | half_valid | !empty`.
- **Ignored input:** `prog_ack` is ignored while `prog_we` is low.

## Timing
- **Reset values:** `prog_we=0`, `prog_addr=0`, `prog_data=0`, `prog_mask=11`, `prog_region=0`, `overflow=0`. `dwnld_busy` follows `downloading`. The FIFO and the half latch are empty.
- **Reset mid-download:** pending and buffered words are discarded, and no flush occurs.
- **Latency:** a completing `ioctl_wr` at cycle n gives `prog_we=1` with that word at n+1, provided the FIFO was empty.
- **Falling-edge flush:** `downloading` low at cycle n (and high at n-1) gives the flushed partial word in the FIFO at n+1.
- **Output stability:** outputs change only after a pop or after a push into an empty FIFO. While `prog_we` is high and `prog_ack` is low, `prog_*` is stable.
- **Pop timing:** a pop at n presents the next entry at n+1, or drops `prog_we` at n+1 if the FIFO is then empty.
- **Throughput:** one word per cycle when `prog_ack` is held high.
- **Arithmetic:** the subtraction is AW bits wide with no wrap. An address above the last start goes to region `REGIONS-1`.

## Test plan
- **Reset defaults:** reset, then write bytes 0x12 @0 and 0x34 @1 with `prog_ack` tied high. Expect one word, `prog_data=16'h3412`, `prog_addr=0`, `prog_region=0`, `mask=00`, and `prog_we` high for exactly 1 cycle at n+1.
- **Region decode:** write bytes at 0x10004 and 0x10005 with default `REG_START`. Expect `prog_region=1`, `prog_addr=2`. Repeat with `SWAB=1` and expect the bytes swapped in `prog_data`.
- **Odd tail flush:** write a byte at 0x7 only, then drop `downloading`. Expect a word at `prog_addr=3` with `mask=01` and the byte in `[15:8]`. `dwnld_busy` falls one cycle after the ack.
- **Backpressure:** hold `prog_ack` low, send 3 full words, then release `prog_ack`. Expect words 0 and 1 delivered in order, word 2 lost, and `overflow=1` until `rst`.
- **Non-sequential writes:** write bytes @0, then @4, then @5. Expect a partial word @0 with `mask=10`, then a full word @2. Also assert reset mid-burst: `prog_we=0` on the next cycle and no further words.
